// File: rtl/lfgm_row_eval.sv
// lfgm_row_eval: row-evaluation datapath for the life-game engine.
// Keeps a three-row sliding window of RAM read data and counts the eight
// neighbours of every column in parallel, one direction per cycle. It then
// presents the next-generation row, or a wall row, on the RAM write bus.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   state_cnt  controller state code (0..17 legal, 18..31 hold everything)
//   rd_en      RAM read strobe; rd_data is valid one cycle later
//   wr_en      RAM write strobe (state 16)
//   adr        RAM address driven by the controller
//   wcf        1 = cell row, 0 = wall row
//   rgen_en    regenerate request (used only when LFSR_RGEN_EN is defined)
//   rd_data    RAM read data
//   wr_data    next-generation row, registered in state 15
//   gen_done   combinational pulse on the last write of a generation (adr 61)
//
// Optional feature: define LFSR_RGEN_EN to build an 80-bit LFSR that
// supplies pseudo-random rows when regeneration is requested.

module lfgm_row_eval #(
  parameter int unsigned COLS = 80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      state_cnt,
  input  logic            rd_en,
  input  logic            wr_en,
  input  logic [5:0]      adr,
  input  logic            wcf,
  input  logic            rgen_en,
  input  logic [COLS-1:0] rd_data,
  output logic [COLS-1:0] wr_data,
  output logic            gen_done
);

  localparam int unsigned ST_W    = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ADR_W   = 6;
  localparam logic [ST_W-1:0] ST_CLR  = ST_W'(5);
  localparam logic [ST_W-1:0] ST_ACC0 = ST_W'(6);
  localparam logic [ST_W-1:0] ST_ACC7 = ST_W'(13);
  localparam logic [ST_W-1:0] ST_EVAL = ST_W'(14);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(15);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(17);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(61);
  // Columns 0 and COLS-1 are walls and always written as 0.
  localparam logic [COLS-1:0] INNER_MASK = {1'b0, {(COLS-2){1'b1}}, 1'b0};

  logic                  rd_vld;
  logic [COLS-1:0]       top, mid, bot;
  logic [CNT_W-1:0]      cnt [COLS];
  logic [COLS-1:0]       nxt;
  logic [COLS-1:0]       nb_c;
  logic [COLS-1:0]       nxt_c;
  logic [COLS-1:0]       row_src_c;
  logic                  st_known_c;
  logic                  st_acc_c;

  assign st_known_c = (state_cnt <= ST_MAX);
  assign st_acc_c   = (state_cnt >= ST_ACC0) && (state_cnt <= ST_ACC7);

  // Read-data window; unknown state codes freeze it along with the read delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
      top    <= '0;
      mid    <= '0;
      bot    <= '0;
    end else if (st_known_c) begin
      rd_vld <= rd_en;
      if (rd_vld) begin
        top <= mid;
        mid <= bot;
        bot <= rd_data;
      end
    end
  end

  // Neighbour bit for the current direction: "left" is c+1, "right" is c-1,
  // with out-of-range indices reading as 0.
  always_comb begin
    nb_c = '0;
    case (state_cnt)
      ST_W'(6):  nb_c = {1'b0, top[COLS-1:1]};
      ST_W'(7):  nb_c = top;
      ST_W'(8):  nb_c = {top[COLS-2:0], 1'b0};
      ST_W'(9):  nb_c = {1'b0, mid[COLS-1:1]};
      ST_W'(10): nb_c = {mid[COLS-2:0], 1'b0};
      ST_W'(11): nb_c = {1'b0, bot[COLS-1:1]};
      ST_W'(12): nb_c = bot;
      ST_W'(13): nb_c = {bot[COLS-2:0], 1'b0};
      default:   nb_c = '0;
    endcase
  end

  // Per-column neighbour counters (max 8, fits in 4 bits).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) cnt[c] <= '0;
    end else if (state_cnt == ST_CLR) begin
      for (int c = 0; c < COLS; c++) cnt[c] <= '0;
    end else if (st_acc_c) begin
      for (int c = 0; c < COLS; c++) cnt[c] <= cnt[c] + CNT_W'(nb_c[c]);
    end
  end

  // Life rule: birth on 3, survival on 2 or 3.
  always_comb begin
    nxt_c = '0;
    for (int c = 0; c < COLS; c++) begin
      nxt_c[c] = (cnt[c] == CNT_W'(3)) | (mid[c] & (cnt[c] == CNT_W'(2)));
    end
    nxt_c = nxt_c & INNER_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt <= '0;
    end else if (state_cnt == ST_EVAL) begin
      nxt <= nxt_c;
    end
  end

`ifdef LFSR_RGEN_EN
  localparam int unsigned LFSR_W = 80;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_fb_c;

  // Fibonacci taps 80,79,43,42 (1-based).
  assign lfsr_fb_c = lfsr[79] ^ lfsr[78] ^ lfsr[42] ^ lfsr[41];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_W'(1);
    end else if (st_acc_c) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb_c};
    end
  end

  assign row_src_c = rgen_en ? lfsr[COLS-1:0] : nxt;
`else
  logic unused_rgen_en;
  assign unused_rgen_en = rgen_en;
  assign row_src_c      = nxt;
`endif

  // Write-data register: loaded in state 15, held through the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data <= '0;
    end else if (state_cnt == ST_LOAD) begin
      wr_data <= wcf ? (row_src_c & INNER_MASK) : '0;
    end
  end

  assign gen_done = wr_en & (adr == LAST_ADR);

endmodule

// File: tb/tb_lfgm_row_eval.sv
// tb_lfgm_row_eval: drives lfgm_row_eval with a modelled controller state
// sequence and RAM, comparing every written row against hand-computed boards.
module tb_lfgm_row_eval;

  localparam int unsigned COLS = 80;
  localparam int ROWS = 62;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      state_cnt;
  logic            rd_en;
  logic            wr_en;
  logic [5:0]      adr;
  logic            wcf;
  logic            rgen_en;
  logic [COLS-1:0] rd_data;
  logic [COLS-1:0] wr_data;
  logic            gen_done;

  always #5 clk = ~clk;

  lfgm_row_eval #(.COLS(COLS)) dut (
    .clk      (clk),
    .rst      (rst),
    .state_cnt(state_cnt),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .adr      (adr),
    .wcf      (wcf),
    .rgen_en  (rgen_en),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .gen_done (gen_done)
  );

  logic [COLS-1:0] ram  [64];
  logic [COLS-1:0] wmem [64];
  logic [COLS-1:0] exp_b [64];
  int wr_cnt = 0;
  int gd_pulses = 0;
  int gd_bad = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Registered-read RAM model.
  always @(posedge clk) if (rd_en) rd_data <= ram[adr];

  // Write capture and gen_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wmem[adr] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (gen_done) begin
      gd_pulses = gd_pulses + 1;
      if (!(wr_en && adr == 6'd61)) gd_bad = gd_bad + 1;
    end
  end

  task automatic check(input string name, input logic [COLS-1:0] act, input logic [COLS-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int st, input logic re, input logic we, input int a);
    state_cnt = 5'(st);
    rd_en     = re;
    wr_en     = we;
    adr       = 6'(a);
    @(posedge clk);
    #1;
  endtask

  // One generation of the controller: flush reads, then 16 states per row.
  // Optionally freezes in unknown states at hold_row, or resets at rst_row.
  task automatic run_gen(input int hold_row, input int rst_row, input logic rg, output bit aborted);
    aborted = 1'b0;
    rgen_en = rg;
    wcf     = 1'b0;
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int a = 0; a < ROWS; a++) begin
      wcf = (a != 0) && (a != ROWS - 1);
      cyc(2, 1, 0, a + 1);
      cyc(3, 0, 0, a);
      cyc(4, 0, 0, a);
      cyc(5, 0, 0, a);
      for (int s = 6; s <= 13; s++) begin
        if (a == rst_row && s == 10) begin
          rst = 1'b1;
          cyc(10, 0, 0, a);
          rst = 1'b0;
          check("rst_wr_data", wr_data, '0);
          check("rst_gen_done", COLS'(gen_done), '0);
          aborted = 1'b1;
          return;
        end
        cyc(s, 0, 0, a);
      end
      cyc(14, 0, 0, a);
      cyc(15, 0, 0, a);
      if (a == hold_row) begin
        // Reads issued in unknown states must not disturb the window.
        cyc(18, 1, 0, 10);
        cyc(25, 1, 0, 10);
        cyc(31, 1, 0, 10);
        check($sformatf("hold_wr_data_row%0d", a), wr_data, exp_b[a]);
      end
      cyc(16, 0, 1, a);
      cyc(17, 0, 0, a);
    end
  endtask

  typedef struct {
    int              pat;
    int              row;
    logic [COLS-1:0] init;
    logic [COLS-1:0] exp;
  } row_vec_t;

  row_vec_t vt[$];

  initial begin
    logic [COLS-1:0] b40, b39_41, blk;
    bit aborted;
    int w0, p0, bad0, src, dup;

    rst = 1'b1; state_cnt = '0; rd_en = 0; wr_en = 0; adr = '0;
    wcf = 0; rgen_en = 0;

    b40 = '0;    b40[40] = 1'b1;
    b39_41 = '0; b39_41[39] = 1'b1; b39_41[40] = 1'b1; b39_41[41] = 1'b1;
    blk = '0;    blk[20] = 1'b1; blk[21] = 1'b1;

    // pattern 0: blinker, 1: block, 2: all-ones, 3: regenerate on empty,
    // 4: blinker with reset mid-generation before a clean run
    vt.push_back('{pat: 0, row: 28, init: '0,  exp: '0});
    vt.push_back('{pat: 0, row: 29, init: b40, exp: '0});
    vt.push_back('{pat: 0, row: 30, init: b40, exp: b39_41});
    vt.push_back('{pat: 0, row: 31, init: b40, exp: '0});
    vt.push_back('{pat: 1, row: 10, init: blk, exp: blk});
    vt.push_back('{pat: 1, row: 11, init: blk, exp: blk});

    cyc(17, 0, 0, 0);
    cyc(17, 0, 0, 0);
    check("reset_wr_data", wr_data, '0);
    check("reset_gen_done", COLS'(gen_done), '0);
    rst = 1'b0;
    cyc(17, 0, 0, 0);

    for (int p = 0; p <= 4; p++) begin
      src = (p == 4) ? 0 : p;
      for (int r = 0; r < 64; r++) begin
        ram[r]   = (p == 2) ? '1 : '0;
        exp_b[r] = '0;
      end
      foreach (vt[i]) begin
        if (vt[i].pat == src) begin
          ram[vt[i].row]   = vt[i].init;
          exp_b[vt[i].row] = vt[i].exp;
        end
      end

      if (p == 4) begin
        run_gen(-1, 31, 1'b0, aborted);
        check("rst_aborted", COLS'(aborted), COLS'(1));
      end

      w0 = wr_cnt; p0 = gd_pulses; bad0 = gd_bad;
      run_gen((p == 0) ? 29 : -1, -1, (p == 3), aborted);

      check($sformatf("p%0d_write_count", p), COLS'(wr_cnt - w0), COLS'(ROWS));
      check($sformatf("p%0d_gen_done_pulses", p), COLS'(gd_pulses - p0), COLS'(1));
      check($sformatf("p%0d_gen_done_misplaced", p), COLS'(gd_bad - bad0), '0);

`ifdef LFSR_RGEN_EN
      if (p == 3) begin
        check("p3_row0", wmem[0], '0);
        check("p3_row61", wmem[61], '0);
        dup = 0;
        for (int r = 1; r <= 60; r++) begin
          check($sformatf("p3_row%0d_nonzero", r), COLS'(wmem[r] != '0), COLS'(1));
          check($sformatf("p3_row%0d_walls", r), COLS'({wmem[r][COLS-1], wmem[r][0]}), '0);
          for (int q = 1; q < r; q++) if (wmem[q] == wmem[r]) dup++;
        end
        check("p3_rows_distinct", COLS'(dup), '0);
        continue;
      end
`endif
      for (int r = 0; r < ROWS; r++) begin
        check($sformatf("p%0d_row%0d", p, r), wmem[r], exp_b[r]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget, required completion");
    $fatal(1);
  end

endmodule
